// File: rtl/lynxTypes.sv
// Shared types for the profiler sampler: sample record layout and serializer states.
package lynxTypes;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] period;
    logic [63:0] bytes;
    logic [63:0] pkts;
    logic [63:0] stalls;
  } prof_sample_t;

  localparam int unsigned PROF_SAMPLE_BEATS = 4;

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} prof_ser_state_t;

  // A counter that went backwards was cleared upstream; its current value is the delta.
  function automatic logic [63:0] prof_delta(input logic [63:0] cur, input logic [63:0] prev);
    return (cur < prev) ? cur : cur - prev;
  endfunction

endpackage

// File: rtl/axis_profiler_sampler_if.sv
// AXI4-Stream bundle carrying the sampler's record beats.
interface axis_profiler_sampler_if #(parameter int unsigned AXI4S_DATA_BITS = 64);
  logic                         tvalid;
  logic                         tready;
  logic [AXI4S_DATA_BITS-1:0]   tdata;
  logic [AXI4S_DATA_BITS/8-1:0] tkeep;
  logic                         tlast;

  modport m (output tvalid, tdata, tkeep, tlast, input tready);
  modport s (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/prof_sample_fifo.sv
// First-word-fall-through FIFO of sample records with full/empty flags.
module prof_sample_fifo
  import lynxTypes::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  prof_sample_t wr_data,
  input  logic         rd_en,
  output prof_sample_t rd_data,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  prof_sample_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_wr;
  logic           do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/axis_profiler_sampler.sv
// Periodic sampler of the profiler counters: windowed deltas, record FIFO and
// a 4-beat AXI4-Stream serializer.
module axis_profiler_sampler
  import lynxTypes::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PERIOD_BITS = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [63:0]            byte_cnt,
  input  logic [63:0]            pkt_cnt,
  input  logic [63:0]            ready_down,
  output logic [31:0]            overflow_cnt,
  output logic [31:0]            sample_cnt,
  axis_profiler_sampler_if.m     m_axis
);
  logic [PERIOD_BITS-1:0] tmr;
  logic [31:0]            seq;
  logic [63:0]            prev_byte, prev_pkt, prev_stall;
  logic                   active, capture;

  prof_sample_t           rec, fifo_head;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;

  prof_ser_state_t        state;
  logic [63:0]            hold_bytes, hold_pkts, hold_stalls;
  logic                   hs;

  assign active    = enable && (period != '0);
  assign capture   = active && (tmr >= period - PERIOD_BITS'(1));
  assign fifo_push = capture && !clear;
  assign hs        = m_axis.tvalid && m_axis.tready;
  assign m_axis.tkeep = '1;

  always_comb begin
    rec        = '0;
    rec.seq    = seq;
    rec.period = 32'(period);
    rec.bytes  = prof_delta(byte_cnt, prev_byte);
    rec.pkts   = prof_delta(pkt_cnt, prev_pkt);
    rec.stalls = prof_delta(ready_down, prev_stall);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tmr          <= '0;
      seq          <= '0;
      prev_byte    <= '0;
      prev_pkt     <= '0;
      prev_stall   <= '0;
      overflow_cnt <= '0;
    end else if (clear || !active || capture) begin
      tmr        <= '0;
      prev_byte  <= byte_cnt;
      prev_pkt   <= pkt_cnt;
      prev_stall <= ready_down;
      if (clear) begin
        seq          <= '0;
        overflow_cnt <= '0;
      end else if (capture) begin
        seq <= seq + 32'd1;
        if (fifo_full && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 32'd1;
      end
    end else begin
      tmr <= tmr + PERIOD_BITS'(1);
    end
  end

  prof_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (fifo_push),
    .wr_data (rec),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pop on IDLE or on the last beat's handshake so records stream back-to-back.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) fifo_pop = (state == IDLE) || (state == B3 && hs);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tdata  <= '0;
      hold_bytes    <= '0;
      hold_pkts     <= '0;
      hold_stalls   <= '0;
      sample_cnt    <= '0;
    end else if (fifo_pop) begin
      if (state == B3) sample_cnt <= sample_cnt + 32'd1;
      state         <= B0;
      m_axis.tvalid <= 1'b1;
      m_axis.tlast  <= 1'b0;
      m_axis.tdata  <= {fifo_head.seq, fifo_head.period};
      hold_bytes    <= fifo_head.bytes;
      hold_pkts     <= fifo_head.pkts;
      hold_stalls   <= fifo_head.stalls;
    end else begin
      case (state)
        B0: if (hs) begin
          state        <= B1;
          m_axis.tdata <= hold_bytes;
        end
        B1: if (hs) begin
          state        <= B2;
          m_axis.tdata <= hold_pkts;
        end
        B2: if (hs) begin
          state        <= B3;
          m_axis.tdata <= hold_stalls;
          m_axis.tlast <= 1'b1;
        end
        B3: if (hs) begin
          sample_cnt    <= sample_cnt + 32'd1;
          state         <= IDLE;
          m_axis.tvalid <= 1'b0;
          m_axis.tlast  <= 1'b0;
          m_axis.tdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_profiler_sampler.sv
// Directed bench for axis_profiler_sampler with hand-computed record contents.
module tb_axis_profiler_sampler;
  logic        clk = 1'b0;
  logic        areset, enable, clear;
  logic [31:0] period;
  logic [63:0] byte_cnt, pkt_cnt, ready_down;
  logic [31:0] overflow_cnt, sample_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          run = 1'b0;
  int unsigned ph = 0;
  bit          saw;
  logic [63:0] b0, b1, p0, p1;

  always #5 clk = ~clk;

  axis_profiler_sampler_if #(.AXI4S_DATA_BITS(64)) axis ();

  axis_profiler_sampler #(.FIFO_DEPTH(16), .PERIOD_BITS(32)) dut (
    .aclk         (clk),
    .areset       (areset),
    .enable       (enable),
    .clear        (clear),
    .period       (period),
    .byte_cnt     (byte_cnt),
    .pkt_cnt      (pkt_cnt),
    .ready_down   (ready_down),
    .overflow_cnt (overflow_cnt),
    .sample_cnt   (sample_cnt),
    .m_axis       (axis)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; counters change just after the edge so they are stable at the next one.
  task automatic tick();
    @(posedge clk);
    #1;
    if (run) begin
      byte_cnt = byte_cnt + 64'd64;
      if (ph == 3) pkt_cnt = pkt_cnt + 64'd1;
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic read_beat(input string tag, input logic [63:0] exp_data, input logic exp_last);
    int unsigned n = 0;
    while (axis.tvalid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, ".vld"}, 64'(axis.tvalid), 64'd1);
    check({tag, ".data"}, axis.tdata, exp_data);
    check({tag, ".last"}, 64'(axis.tlast), 64'(exp_last));
    tick();
  endtask

  task automatic read_record(input string tag, input logic [31:0] s, input logic [31:0] p,
                             input logic [63:0] db, input logic [63:0] dp, input logic [63:0] ds);
    read_beat({tag, ".b0"}, {s, p}, 1'b0);
    read_beat({tag, ".b1"}, db, 1'b0);
    read_beat({tag, ".b2"}, dp, 1'b0);
    read_beat({tag, ".b3"}, ds, 1'b1);
  endtask

  initial begin
    areset = 1'b1; enable = 1'b0; clear = 1'b0; period = '0;
    byte_cnt = '0; pkt_cnt = '0; ready_down = '0;
    axis.tready = 1'b1;
    repeat (3) tick();
    check("rst.tvalid", 64'(axis.tvalid), 64'd0);
    check("rst.tlast", 64'(axis.tlast), 64'd0);
    check("rst.tdata", axis.tdata, 64'd0);
    check("rst.ovf", 64'(overflow_cnt), 64'd0);
    check("rst.scnt", 64'(sample_cnt), 64'd0);
    check("rst.tkeep", 64'(axis.tkeep), 64'hff);
    areset = 1'b0;
    tick();

    // Basic record: period 10, +64 bytes/cycle, +1 pkt every 4 cycles.
    period = 32'd10; run = 1'b1;
    repeat (5) tick();
    b0 = byte_cnt; p0 = pkt_cnt;
    tick();
    enable = 1'b1;
    repeat (9) tick();
    b1 = byte_cnt; p1 = pkt_cnt;
    tick();
    enable = 1'b0;
    check("basic.lat0", 64'(axis.tvalid), 64'd0);
    tick();
    check("basic.lat1", 64'(axis.tvalid), 64'd1);
    read_record("basic", 32'd0, 32'd10, 64'd640, p1 - p0, 64'd0);
    check("basic.scnt", 64'(sample_cnt), 64'd1);

    // Profiler cleared between captures: prev 1000, now 200.
    run = 1'b0;
    byte_cnt = 64'd1000; ready_down = 64'd5;
    tick();
    enable = 1'b1; period = 32'd4;
    repeat (3) tick();
    byte_cnt = 64'd200; ready_down = 64'd12;
    tick();
    enable = 1'b0;
    read_record("profclr", 32'd1, 32'd4, 64'd200, 64'd0, 64'd7);

    // Enable gating, then a period-5 window after enable.
    run = 1'b1; enable = 1'b0; period = 32'd5; saw = 1'b0;
    repeat (50) begin tick(); if (axis.tvalid) saw = 1'b1; end
    enable = 1'b1; period = 32'd0;
    repeat (50) begin tick(); if (axis.tvalid) saw = 1'b1; end
    check("gate.novalid", 64'(saw), 64'd0);
    enable = 1'b0; period = 32'd5;
    b0 = byte_cnt; p0 = pkt_cnt;
    tick();
    enable = 1'b1;
    repeat (4) tick();
    b1 = byte_cnt; p1 = pkt_cnt;
    tick();
    enable = 1'b0;
    check("gate.lat5", 64'(axis.tvalid), 64'd0);
    tick();
    check("gate.lat6", 64'(axis.tvalid), 64'd1);
    read_record("gate", 32'd2, 32'd5, 64'd320, p1 - p0, 64'd0);

    // Clear coinciding with a capture while a record is stalled in B0.
    axis.tready = 1'b0; period = 32'd4;
    b0 = byte_cnt; p0 = pkt_cnt;
    tick();
    enable = 1'b1;
    repeat (3) tick();
    b1 = byte_cnt; p1 = pkt_cnt;
    tick();
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b0;
    repeat (5) tick();
    check("clr.stall_vld", 64'(axis.tvalid), 64'd1);
    check("clr.stall_b0", axis.tdata, {32'd3, 32'd4});
    axis.tready = 1'b1;
    read_record("clr.inflight", 32'd3, 32'd4, 64'd256, p1 - p0, 64'd0);
    saw = 1'b0;
    repeat (10) begin tick(); if (axis.tvalid) saw = 1'b1; end
    check("clr.norec", 64'(saw), 64'd0);
    run = 1'b0;
    tick();
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    read_record("clr.seq0", 32'd0, 32'd4, 64'd0, 64'd0, 64'd0);
    check("clr.scnt", 64'(sample_cnt), 64'd5);

    // Backpressure overflow: 50 captures, 1 held + 16 buffered + 33 dropped.
    axis.tready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b1; period = 32'd4;
    repeat (200) tick();
    enable = 1'b0;
    check("ovf.cnt", 64'(overflow_cnt), 64'd33);
    check("ovf.vld", 64'(axis.tvalid), 64'd1);
    check("ovf.hold_b0", axis.tdata, {32'd0, 32'd4});
    axis.tready = 1'b1;
    for (int i = 0; i < 17; i++)
      read_record($sformatf("ovf.rec%0d", i), 32'(i), 32'd4, 64'd0, 64'd0, 64'd0);
    saw = 1'b0;
    repeat (10) begin tick(); if (axis.tvalid) saw = 1'b1; end
    check("ovf.drained", 64'(saw), 64'd0);
    check("ovf.scnt", 64'(sample_cnt), 64'd22);

    // Reset during B2 of an in-flight record.
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    read_beat("rst.b0", {32'd50, 32'd4}, 1'b0);
    read_beat("rst.b1", 64'd0, 1'b0);
    check("rst.b2vld", 64'(axis.tvalid), 64'd1);
    areset = 1'b1;
    #1;
    check("rst.async_vld", 64'(axis.tvalid), 64'd0);
    check("rst.async_ovf", 64'(overflow_cnt), 64'd0);
    check("rst.async_scnt", 64'(sample_cnt), 64'd0);
    tick();
    areset = 1'b0;
    saw = 1'b0;
    repeat (5) begin tick(); if (axis.tvalid) saw = 1'b1; end
    check("rst.noresume", 64'(saw), 64'd0);
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    read_record("rst.next", 32'd0, 32'd4, 64'd0, 64'd0, 64'd0);
    check("rst.scnt", 64'(sample_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axis_profiler_sampler.md
# axis_profiler_sampler

Periodic sampler that consumes the three 64-bit running counters of the AXI4S register-array profiler (`byte_cnt`, `pkt_cnt`, `ready_down`). Each programmable interval it computes per-window deltas. Each sample is buffered in a small FIFO and emitted as a 4-beat record on a 64-bit AXI4S stream. It sits directly downstream of the profiler in the same `aclk` domain and feeds the host-bound telemetry path.

## Interface
- `FIFO_DEPTH`, 16: number of buffered sample records; power of two, at least 2.
- `PERIOD_BITS`, 32: width of the interval timer and of `period`.
- `aclk`  in  1  block clock; the profiler counters are in this domain.
- `areset`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  sampling enable.
- `clear`  in  1  synchronous statistics clear, one-cycle pulse.
- `period`  in  PERIOD_BITS  window length in cycles; 0 disables sampling.
- `byte_cnt`, `pkt_cnt`, `ready_down`  in  64 each  profiler running counters.
- `overflow_cnt`  out  32  samples dropped because the FIFO was full; saturates at all-ones.
- `sample_cnt`  out  32  records fully transmitted; wraps modulo 2^32.
- `m_axis`  AXI4S.m  `AXI4S_DATA_BITS`=64  sample stream; `tkeep` is all-ones on every beat.

## Operation
- **Timer (`tmr`).**
  - While `enable`=0 or `period`=0: `tmr`=0, and the `prev_*` registers load the current counter inputs every cycle.
  - While `enable`=1 and `period`≠0: `tmr` increments each cycle.
  - Capture occurs when `tmr` ≥ `period`−1; `tmr` then returns to 0. Using ≥ means a shrinking `period` takes effect on the next cycle.
- **Capture.**
  - Compute `d_x` = `cur_x` − `prev_x` for each of the three counters.
  - If `cur_x` < `prev_x` (the profiler was cleared), `d_x` = `cur_x`.
  - Then set `prev_x` ← `cur_x` and `seq` ← `seq`+1, whether or not the sample is stored.
- **FIFO write.**
  - The record {`seq`, `period`, `d_byte`, `d_pkt`, `d_stall`} is written at the capture edge.
  - If the FIFO is full, the record is dropped and `overflow_cnt` increments (saturating). Gaps in `seq` expose the drop downstream.
- **Serializer FSM.**
  - States are IDLE, B0, B1, B2, B3.
  - IDLE → B0 when the FIFO is non-empty; the record is popped into a hold register.
  - Bn → Bn+1 on `tvalid`&`tready`.
  - B3 handshake: `sample_cnt`++. The FSM goes to B0 if the FIFO is non-empty (popping the next record in the same edge), otherwise to IDLE.
  - Beat contents: B0 carries {`seq`[31:0], `period` zero-extended to 32} with `seq` in [63:32]; B1 = `d_byte`; B2 = `d_pkt`; B3 = `d_stall` with `tlast`=1.
- **Clear pulse.**
  - Zeroes `tmr`, `seq` and `overflow_cnt`, and rebases `prev_*` to the current inputs.
  - Does not flush the FIFO and does not abort the in-flight record.
  - If `clear` coincides with a capture, `clear` wins and no sample is written.
- **Handshake.** Once `tvalid`=1, `tdata` and `tlast` hold stable until the handshake completes.

## Timing
- **Reset values.** `m_axis.tvalid`=0, `tlast`=0, `tdata`=0, `overflow_cnt`=0, `sample_cnt`=0. Internally: FIFO empty, FSM IDLE, `tmr`=0, `seq`=0, `prev_*`=0.
- **Reset mid-record.** `areset` drops `tvalid` immediately. No partial record is resumed after release.
- **Output latency.** From the capture edge to B0 `tvalid` is 1 cycle when the FSM is IDLE and the FIFO is empty.
- **Throughput.** One beat per cycle. Back-to-back records have no idle cycle. `period` ≥ 4 with `tready`=1 never overflows.
- **Sampling rule.** Counter inputs are sampled at the capture edge only. The profiler's one-cycle output register delay is inherent in its outputs and is not compensated here.

## Structure
- **Shared package (`lynxTypes`).**
  - `prof_sample_t`: packed struct {`seq` 32, `period` 32, `bytes` 64, `pkts` 64, `stalls` 64}.
  - `PROF_SAMPLE_BEATS` = 4.
  - `prof_ser_state_t`: enum IDLE, B0..B3.
- **Sub-module `prof_sample_fifo`.** Synchronous first-word-fall-through FIFO of `prof_sample_t`, `FIFO_DEPTH` entries, with full/empty flags and the same async reset.
- **Top level.** Holds the timer, the delta arithmetic, the serializer FSM and the status counters.

## Test plan
- **Basic record.** `period`=10, `byte_cnt` +64/cycle, `pkt_cnt` +1 every 4 cycles, `tready`=1 → first record: B0 = {0, 10}, B1 = 640, B2 = 2 or 3 (phase-dependent, checked against the model), B3 = 0, `tlast` only on B3, `sample_cnt`=1.
- **Backpressure overflow.** `tready`=0 for 200 cycles, `period`=4, depth 16 → 50 captures: 1 in the hold register, 16 in the FIFO, `overflow_cnt`=33. After release, B0 `seq` values read 0..16 in order.
- **Profiler cleared.** `prev_byte`=1000 and the next capture sees `byte_cnt`=200 → B1 = 200.
- **Enable gating.** `enable`=0 or `period`=0 for 100 cycles → no `tvalid`. Raise `enable` with `period`=5 → first record 6 cycles later; deltas cover only the post-enable window.
- **Clear vs capture.** `clear` coincides with a capture → no record; `seq` restarts at 0; an in-flight record completes intact.
- **Reset mid-record.** `areset` pulse during B2 → `tvalid` low within the same cycle. After release, the next record starts at B0 with `seq`=0.
